// File: rtl/jtpang_pkg.sv
// Shared types and constants for the object RAM arbiter and its RAM.
package jtpang_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } obj_st_e;

  localparam int OBJ_AW = 9;

endpackage

// File: rtl/jtframe_ram.sv
// Single-port RAM with synchronous read; the read returns the pre-write contents.
module jtframe_ram #(
  parameter int aw = 9,
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic [aw-1:0] addr,
  input  logic [dw-1:0] data,
  input  logic          we,
  output logic [dw-1:0] q
);

  logic [dw-1:0] mem [2**aw];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= data;
    q <= mem[addr];
  end

endmodule

// File: rtl/jtpang_objram_arb.sv
// Object RAM owner on the CPU bus: turns the object engine's busrq into a Z80
// BUSRQ/BUSAK exchange, serves DMA reads while granted, and generates dma_go.
module jtpang_objram_arb
  import jtpang_pkg::*;
#(
  parameter int GO_LEN  = 4,
  parameter int TIMEOUT = 4096,
  parameter int AW      = OBJ_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_dout,
  input  logic          cpu_we,
  input  logic          obj_cs,
  output logic [7:0]    cpu_din,
  input  logic          dma_trig,
  output logic          cpu_busrq_n,
  input  logic          cpu_busak_n,
  output logic          dma_go,
  input  logic          busrq,
  output logic          busak_n,
  input  logic [AW-1:0] dma_addr,
  output logic [7:0]    dma_din,
  output logic          err
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = $clog2(GO_LEN + 1);

  // Handshake: the engine holds busrq high for the whole transfer; busak_n
  // goes low only after the CPU has answered BUSRQ with BUSAK, and both sides
  // are released when busrq drops. A new request waits until the CPU lets go.
  obj_st_e       st, st_nx;
  logic          cpu_busrq_nx, busak_nx;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] go_cnt;
  logic          trig_q, rd_ok, grant_q;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      cpu_busrq_n <= 1'b1;
      busak_n     <= 1'b1;
    end else begin
      st          <= st_nx;
      cpu_busrq_n <= cpu_busrq_nx;
      busak_n     <= busak_nx;
    end
  end

  always_comb begin
    st_nx        = st;
    cpu_busrq_nx = cpu_busrq_n;
    busak_nx     = busak_n;
    case (st)
      IDLE: begin
        if (busrq) begin
          st_nx        = REQ;
          cpu_busrq_nx = 1'b0;
        end
      end
      REQ: begin
        if (!cpu_busak_n) begin
          st_nx    = GRANT;
          busak_nx = 1'b0;
        end else if (!busrq) begin
          st_nx        = RELEASE;
          cpu_busrq_nx = 1'b1;
        end
      end
      GRANT: begin
        if (!busrq) begin
          st_nx        = RELEASE;
          busak_nx     = 1'b1;
          cpu_busrq_nx = 1'b1;
        end
      end
      RELEASE: begin
        cpu_busrq_nx = 1'b1;
        busak_nx     = 1'b1;
        if (cpu_busak_n) st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  // Timeout saturates at TIMEOUT-1 so err stays set without the count wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else if (st == IDLE) begin
      tcnt <= '0;
    end else if (st == REQ) begin
      if (tcnt == TW'(TIMEOUT - 1)) err  <= 1'b1;
      else                          tcnt <= tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q <= 1'b0;
      go_cnt <= '0;
    end else begin
      trig_q <= dma_trig;
      if (dma_trig && !trig_q && st == IDLE && go_cnt == '0)
        go_cnt <= GW'(GO_LEN);
      else if (go_cnt != '0)
        go_cnt <= go_cnt - 1'b1;
    end
  end

  assign dma_go = (go_cnt != '0);

  // grant_q records who owned the address on the last read so the data is
  // steered to the right port one clock later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ok   <= 1'b0;
      grant_q <= 1'b0;
    end else begin
      rd_ok   <= 1'b1;
      grant_q <= (st == GRANT);
    end
  end

  assign ram_addr = (st == GRANT) ? dma_addr : cpu_addr;
  assign ram_we   = obj_cs & cpu_we & (st != GRANT);

  jtframe_ram #(.aw(AW), .dw(8)) u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .data (cpu_dout),
    .we   (ram_we),
    .q    (ram_q)
  );

  assign cpu_din = !rd_ok ? 8'h00 : (grant_q ? 8'hFF : ram_q);
  assign dma_din = (rd_ok && grant_q) ? ram_q : 8'h00;

  logic unused_ok;
  assign unused_ok = pxl_cen;

endmodule

// File: tb/tb_jtpang_objram_arb.sv
// Bench for jtpang_objram_arb: RAM contents modelled by an array, handshake
// and pulse timing predicted from the protocol rules.
module tb_jtpang_objram_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pxl_cen = 1'b0;
  logic [8:0] cpu_addr = '0;
  logic [7:0] cpu_dout = '0;
  logic       cpu_we = 1'b0;
  logic       obj_cs = 1'b0;
  logic [7:0] cpu_din;
  logic       dma_trig = 1'b0;
  logic       cpu_busrq_n;
  logic       cpu_busak_n = 1'b1;
  logic       dma_go;
  logic       busrq = 1'b0;
  logic       busak_n;
  logic [8:0] dma_addr = '0;
  logic [7:0] dma_din;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [512];
  logic [8:0] wr_q [$];

  jtpang_objram_arb dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout), .cpu_we(cpu_we), .obj_cs(obj_cs), .cpu_din(cpu_din),
    .dma_trig(dma_trig), .cpu_busrq_n(cpu_busrq_n), .cpu_busak_n(cpu_busak_n),
    .dma_go(dma_go), .busrq(busrq), .busak_n(busak_n), .dma_addr(dma_addr),
    .dma_din(dma_din), .err(err)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) pxl_cen <= ~pxl_cen;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic cpu_write(input logic [8:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_dout = d; obj_cs = 1'b1; cpu_we = 1'b1;
    tick();
    obj_cs = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic cpu_read(input logic [8:0] a, output logic [7:0] d);
    cpu_addr = a; obj_cs = 1'b1; cpu_we = 1'b0;
    tick();
    d = cpu_din;
    obj_cs = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({cpu_busrq_n, busak_n, dma_go, err} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_ctrl got busrq_n,busak_n,go,err=%b expected 1100",
               {cpu_busrq_n, busak_n, dma_go, err});
    end
    checks++;
    if (cpu_din !== 8'h00 || dma_din !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got cpu_din=%h dma_din=%h expected 00 00", cpu_din, dma_din);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cpu_rw();
    logic [7:0] d;
    logic [8:0] a;
    cpu_write(9'h010, 8'h5A);
    mem[9'h010] = 8'h5A;
    wr_q.push_back(9'h010);
    cpu_read(9'h010, d);
    checks++;
    if (d !== 8'h5A) begin
      errors++;
      $display("FAIL cpu_rw_5a got %h expected 5a", d);
    end
    for (int i = 0; i < 16; i++) begin
      a = 9'($urandom_range(32, 511));
      d = 8'($urandom_range(0, 255));
      cpu_write(a, d);
      mem[a] = d;
      wr_q.push_back(a);
    end
    for (int i = 0; i < 16; i++) begin
      a = wr_q[$urandom_range(0, wr_q.size() - 1)];
      cpu_read(a, d);
      checks++;
      if (d !== mem[a]) begin
        errors++;
        $display("FAIL cpu_rw_rand addr=%h got %h expected %h", a, d, mem[a]);
      end
    end
  endtask

  task automatic test_dma_go();
    logic [5:0] pattern;
    int left;
    logic exp_go;
    pattern = 6'b001101;  // bit k is dma_trig before edge k
    left = 0;
    for (int k = 0; k < 6; k++) begin
      logic prev;
      prev = dma_trig;
      dma_trig = pattern[k];
      tick();
      if (left > 0) left--;
      else if (pattern[k] && !prev) left = 4;
      exp_go = (left > 0);
      checks++;
      if (dma_go !== exp_go) begin
        errors++;
        $display("FAIL dma_go_pulse edge=%0d got %b expected %b", k, dma_go, exp_go);
      end
    end
    dma_trig = 1'b0;
    tick();
  endtask

  task automatic test_handshake(input int iter);
    int delay;
    logic [8:0] a;
    busrq = 1'b1;
    tick();
    checks++;
    if (cpu_busrq_n !== 1'b0 || busak_n !== 1'b1) begin
      errors++;
      $display("FAIL hs_req got busrq_n=%b busak_n=%b expected 0 1", cpu_busrq_n, busak_n);
    end
    delay = (iter == 0) ? 10 : $urandom_range(2, 12);
    for (int i = 0; i < delay; i++) begin
      tick();
      checks++;
      if (busak_n !== 1'b1) begin
        errors++;
        $display("FAIL hs_wait cycle=%0d got busak_n=%b expected 1", i, busak_n);
      end
    end
    cpu_busak_n = 1'b0;
    tick();
    checks++;
    if (busak_n !== 1'b0 || cpu_busrq_n !== 1'b0) begin
      errors++;
      $display("FAIL hs_grant got busak_n=%b busrq_n=%b expected 0 0", busak_n, cpu_busrq_n);
    end
    for (int i = 0; i < 6; i++) begin
      a = (iter == 0 && i == 0) ? 9'h010 : wr_q[$urandom_range(0, wr_q.size() - 1)];
      dma_addr = a;
      tick();
      checks++;
      if (dma_din !== mem[a] || cpu_din !== 8'hFF) begin
        errors++;
        $display("FAIL hs_dma_rd addr=%h got dma_din=%h cpu_din=%h expected %h ff",
                 a, dma_din, cpu_din, mem[a]);
      end
    end
    if (iter == 0) begin
      cpu_write(9'h010, 8'hFF);  // must be dropped
      dma_trig = 1'b1;
      tick();
      checks++;
      if (dma_go !== 1'b0) begin
        errors++;
        $display("FAIL hs_go_in_grant got dma_go=%b expected 0", dma_go);
      end
      dma_trig = 1'b0;
    end
    busrq = 1'b0;
    tick();
    checks++;
    if (busak_n !== 1'b1 || cpu_busrq_n !== 1'b1) begin
      errors++;
      $display("FAIL hs_release got busak_n=%b busrq_n=%b expected 1 1", busak_n, cpu_busrq_n);
    end
    busrq = 1'b1;  // held off while the CPU still holds BUSAK
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (cpu_busrq_n !== 1'b1 || busak_n !== 1'b1) begin
        errors++;
        $display("FAIL hs_holdoff got busrq_n=%b busak_n=%b expected 1 1", cpu_busrq_n, busak_n);
      end
    end
    busrq = 1'b0;
    cpu_busak_n = 1'b1;
    tick(); tick();
    checks++;
    if (cpu_busrq_n !== 1'b1) begin
      errors++;
      $display("FAIL hs_idle got busrq_n=%b expected 1", cpu_busrq_n);
    end
    if (iter == 0) begin
      logic [7:0] d;
      cpu_read(9'h010, d);
      checks++;
      if (d !== 8'h5A) begin
        errors++;
        $display("FAIL hs_write_dropped got %h expected 5a", d);
      end
    end
  endtask

  task automatic test_withdraw();
    busrq = 1'b1;
    tick();
    checks++;
    if (cpu_busrq_n !== 1'b0) begin
      errors++;
      $display("FAIL wd_req got busrq_n=%b expected 0", cpu_busrq_n);
    end
    tick(); tick();
    busrq = 1'b0;
    tick();
    checks++;
    if (cpu_busrq_n !== 1'b1 || busak_n !== 1'b1) begin
      errors++;
      $display("FAIL wd_release got busrq_n=%b busak_n=%b expected 1 1", cpu_busrq_n, busak_n);
    end
    tick(); tick();
    dma_trig = 1'b1;  // only honoured once back in IDLE
    tick();
    checks++;
    if (dma_go !== 1'b1 || busak_n !== 1'b1) begin
      errors++;
      $display("FAIL wd_idle got dma_go=%b busak_n=%b expected 1 1", dma_go, busak_n);
    end
    dma_trig = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_timeout();
    busrq = 1'b1;
    tick();
    for (int i = 0; i < 4095; i++) tick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL to_early got err=%b expected 0 after 4095 cycles", err);
    end
    tick();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL to_set got err=%b expected 1 after 4096 cycles", err);
    end
    repeat (20) tick();
    cpu_busak_n = 1'b0;
    tick();
    checks++;
    if (busak_n !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL to_grant got busak_n=%b err=%b expected 0 1", busak_n, err);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (busak_n !== 1'b1 || cpu_busrq_n !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL to_rst got busak_n=%b busrq_n=%b err=%b expected 1 1 0",
               busak_n, cpu_busrq_n, err);
    end
    rst = 1'b0;
    busrq = 1'b0;
    cpu_busak_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (err !== 1'b0 || cpu_busrq_n !== 1'b1) begin
      errors++;
      $display("FAIL to_after got err=%b busrq_n=%b expected 0 1", err, cpu_busrq_n);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_rw();
    test_dma_go();
    for (int it = 0; it < 3; it++) test_handshake(it);
    test_withdraw();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
